// File: rtl/instr_boot_loader.sv
// instr_boot_loader: byte-stream program loader for the pipeline's instruction memory.
// Receives a 16-bit little-endian word count followed by little-endian 32-bit words.
// Each word is written into IM through load_we/load_addr/load_instr. The core is held
// frozen (load_enable) while a load is in progress.
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_boot_loader #(
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 256,
    parameter int unsigned       TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,        // active-high synchronous reset
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              load_enable,
    output logic              load_we,
    output logic [ADDR_W-1:0] load_addr,
    output logic [31:0]       load_instr,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR0 = 3'd1;
    localparam logic [2:0] S_HDR1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
`ifdef INSTR_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK  = 3'd4;
    // The last data word hands over to the checksum byte.
    localparam logic [2:0] S_TAIL = S_CHK;
`else
    localparam logic [2:0] S_TAIL = 3'd5;
`endif
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    logic [2:0]  state;
    logic [1:0]  byte_cnt;     // byte position inside the current word
    logic [15:0] word_cnt;     // words already written
    logic [15:0] word_total;   // N from the header
    logic [31:0] to_cnt;       // idle cycles while a byte is awaited
    logic [7:0]  hdr_lo;
    logic [23:0] sr;           // b2,b1,b0 of the word being assembled
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        busy;
    logic        accept;
    logic [15:0] hdr_n;
    logic        word_last;

    // Decode the load-in-progress states and the byte handshake.
    always_comb begin
        busy = 1'b0;
        case (state)
            S_HDR0, S_HDR1, S_DATA: busy = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CHK:                  busy = 1'b1;
`endif
            default:                busy = 1'b0;
        endcase
        // The write cycle stalls the stream, capping throughput at 4 bytes per 5 cycles.
        s_ready     = busy & ~load_we;
        load_enable = busy;
        done        = (state == S_DONE);
        error       = (state == S_ERR);
        accept      = s_valid & s_ready;
        hdr_n       = {s_data, hdr_lo};
        word_last   = ((word_cnt + 16'd1) == word_total);
    end

    // Load sequencer: header parse, word assembly, IM write strobe, timeout and checksum.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            word_total <= '0;
            to_cnt     <= '0;
            hdr_lo     <= '0;
            sr         <= '0;
            load_we    <= 1'b0;
            load_addr  <= BASE_ADDR;
            load_instr <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            load_we <= 1'b0;
            if (!busy) begin
                // IDLE, DONE, ERROR: only start matters; stream bytes are ignored.
                if (start) begin
                    state     <= S_HDR0;
                    byte_cnt  <= '0;
                    word_cnt  <= '0;
                    to_cnt    <= '0;
                    load_addr <= BASE_ADDR;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum      <= '0;
`endif
                end
            end else begin
                if (accept) begin
                    to_cnt <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum   <= csum ^ s_data;
`endif
                end else if (s_ready) begin
                    to_cnt <= to_cnt + 32'd1;
                    if ((TIMEOUT != 0) && ((to_cnt + 32'd1) == TIMEOUT))
                        state <= S_ERR;
                end

                case (state)
                    S_HDR0: begin
                        if (accept) begin
                            hdr_lo <= s_data;
                            state  <= S_HDR1;
                        end
                    end
                    S_HDR1: begin
                        if (accept) begin
                            word_total <= hdr_n;
                            if (hdr_n == 16'd0)
                                state <= S_DONE;
                            else if ({16'd0, hdr_n} > MAX_WORDS)
                                state <= S_ERR;
                            else
                                state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (load_we) begin
                            // Write cycle: advance to the next IM slot.
                            load_addr <= load_addr + ADDR_W'(4);
                            word_cnt  <= word_cnt + 16'd1;
                            if (word_last)
                                state <= S_TAIL;
                        end else if (accept) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            sr       <= {s_data, sr[23:8]};
                            if (byte_cnt == 2'd3) begin
                                load_we    <= 1'b1;
                                load_instr <= {s_data, sr};
                            end
                        end
                    end
`ifdef INSTR_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (accept)
                            state <= (s_data == csum) ? S_DONE : S_ERR;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_boot_loader.sv
// tb_instr_boot_loader: directed scenarios for instr_boot_loader with a small timeout.
module tb_instr_boot_loader;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        load_enable;
    logic        load_we;
    logic [63:0] load_addr;
    logic [31:0] load_instr;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_viol = 0;

    logic [63:0] wa_q[$];
    logic [31:0] wd_q[$];

    logic [7:0]  prog[10] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    logic [63:0] exp_addr[2] = '{64'd0, 64'd4};
    logic [31:0] exp_instr[2] = '{32'h00100513, 32'h00200593};

    instr_boot_loader #(
        .ADDR_W(64), .BASE_ADDR(64'd0), .MAX_WORDS(256), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .load_enable(load_enable), .load_we(load_we),
        .load_addr(load_addr), .load_instr(load_instr), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every IM write; s_ready must be low in the write cycle.
    always @(negedge clk) begin
        if (load_we) begin
            wa_q.push_back(load_addr);
            wd_q.push_back(load_instr);
            if (s_ready) rdy_viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        s_valid = 1'b0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_byte: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end
        tick();
        s_valid = 1'b0;
        s_data  = 8'h00;
    endtask

    // mode 0: full rate; mode 1: s_valid toggling plus longer mid-word gaps.
    task automatic send_prog(input int mode);
        for (int i = 0; i < 10; i++)
            send_byte(prog[i], (mode == 0) ? 0 : ((i % 4 == 3) ? 5 : 1));
    endtask

    function automatic logic [7:0] prog_xor();
        logic [7:0] x = 8'h00;
        for (int i = 0; i < 10; i++) x ^= prog[i];
        return x;
    endfunction

    task automatic send_csum();
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(prog_xor(), 0);
`endif
    endtask

    task automatic wait_flag(input int limit);
        int n = 0;
        while (!done && !error && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b0;
        checks++;
        if ({s_ready, load_enable, load_we, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b required 00000", {s_ready, load_enable, load_we, done, error});
        end
        checks++;
        if (load_addr !== 64'd0 || load_instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h instr=%h required 0/0", load_addr, load_instr);
        end
        // Bytes offered in IDLE are ignored.
        s_valid = 1'b1; s_data = 8'hAA;
        tick();
        checks++;
        if (s_ready !== 1'b0 || load_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: s_ready=%b load_enable=%b required 0/0", s_ready, load_enable);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t0;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        t0 = cyc;
        checks++;
        if (load_enable !== 1'b1 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_start: load_enable=%b s_ready=%b required 1/1", load_enable, s_ready);
        end
        // A start mid-load must be ignored.
        send_byte(prog[0], 0);
        pulse_start();
        for (int i = 1; i < 10; i++) send_byte(prog[i], 0);
        send_csum();
        wait_flag(10);
        checks++;
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (cyc - t0 !== 14) begin
`else
        if (cyc - t0 !== 13) begin
`endif
            errors++;
            $display("FAIL b2b_latency: got %0d cycles from start to done", cyc - t0);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || load_enable !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: done=%b error=%b load_enable=%b s_ready=%b required 1/0/0/0",
                     done, error, load_enable, s_ready);
        end
        checks++;
        if (wa_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes required 2", wa_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wa_q[i] !== exp_addr[i] || wd_q[i] !== exp_instr[i]) begin
                    errors++;
                    $display("FAIL b2b_write%0d: got %h/%h required %h/%h", i, wa_q[i], wd_q[i],
                             exp_addr[i], exp_instr[i]);
                end
            end
        end
    endtask

    task automatic test_empty();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++;
        if (done !== 1'b0 || load_enable !== 1'b1) begin
            errors++;
            $display("FAIL empty_restart: done=%b load_enable=%b required 0/1", done, load_enable);
        end
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_flag(2);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || load_enable !== 1'b0 || wa_q.size() !== 0) begin
            errors++;
            $display("FAIL empty_done: done=%b error=%b load_enable=%b writes=%0d required 1/0/0/0",
                     done, error, load_enable, wa_q.size());
        end
    endtask

    task automatic test_oversize();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);   // N = 257
        wait_flag(2);
        s_valid = 1'b1; s_data = 8'h55;
        repeat (3) tick();
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || s_ready !== 1'b0 || load_enable !== 1'b0 || wa_q.size() !== 0) begin
            errors++;
            $display("FAIL oversize: error=%b done=%b s_ready=%b load_enable=%b writes=%0d required 1/0/0/0/0",
                     error, done, s_ready, load_enable, wa_q.size());
        end
        s_valid = 1'b0;
    endtask

    task automatic test_throttle_timeout();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL throttle_clear: error=%b required 0", error);
        end
        send_prog(1);
        send_csum();
        wait_flag(10);
        checks++;
        if (done !== 1'b1 || wa_q.size() !== 2) begin
            errors++;
            $display("FAIL throttle_done: done=%b writes=%0d required 1/2", done, wa_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wa_q[i] !== exp_addr[i] || wd_q[i] !== exp_instr[i]) begin
                    errors++;
                    $display("FAIL throttle_write%0d: got %h/%h required %h/%h", i, wa_q[i], wd_q[i],
                             exp_addr[i], exp_instr[i]);
                end
            end
        end
        // Stall mid-word: error exactly TMO cycles after the last accepted byte.
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        repeat (TMO - 1) tick();
        checks++;
        if (error !== 1'b0 || load_enable !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: error=%b load_enable=%b required 0/1", error, load_enable);
        end
        tick();
        checks++;
        if (error !== 1'b1 || load_enable !== 1'b0) begin
            errors++;
            $display("FAIL timeout_hit: error=%b load_enable=%b required 1/0", error, load_enable);
        end
    endtask

    task automatic test_reset_midload();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        rst_n = 1'b1;
        tick();
        checks++;
        if ({s_ready, load_enable, load_we, done, error} !== 5'b0 || load_addr !== 64'd0 || load_instr !== 32'd0) begin
            errors++;
            $display("FAIL midload_reset: ctl=%b addr=%h instr=%h required 00000/0/0",
                     {s_ready, load_enable, load_we, done, error}, load_addr, load_instr);
        end
        rst_n = 1'b0;
        tick();
        pulse_start();
        send_prog(0);
        send_csum();
        wait_flag(10);
        checks++;
        if (done !== 1'b1 || wa_q.size() !== 2) begin
            errors++;
            $display("FAIL midload_reload: done=%b writes=%0d required 1/2", done, wa_q.size());
        end else begin
            checks++;
            if (wa_q[1] !== 64'd4 || wd_q[1] !== 32'h00200593 || wd_q[0] !== 32'h00100513) begin
                errors++;
                $display("FAIL midload_data: got %h/%h/%h required 00100513/4/00200593",
                         wd_q[0], wa_q[1], wd_q[1]);
            end
        end
    endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_prog(0);
        send_byte(prog_xor() ^ 8'hFF, 0);
        wait_flag(4);
        checks++;
        if (error !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL csum_bad: error=%b done=%b required 1/0", error, done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_empty();
        test_oversize();
        test_throttle_timeout();
        test_reset_midload();
`ifdef INSTR_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        checks++;
        if (rdy_viol !== 0) begin
            errors++;
            $display("FAIL ready_in_write: %0d write cycles with s_ready=1, required 0", rdy_viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
